// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit and its branch target buffer.
// Pure declarations; no latency of its own.
// No flow control; consumed by fetch_pc_unit and btb_direct_mapped.
package fetch_pc_unit_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // 2-bit direction counter encodings
  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  // Tag is held as a right-justified 32-bit field so the entry type does not
  // depend on the table size; unused upper bits stay zero and trim away.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  // Saturating counter step toward the resolved direction.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_direct_mapped.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; training takes effect on the next clock edge.
// No backpressure: an update presented with upd_valid is always applied.
module btb_direct_mapped
  import fetch_pc_unit_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        lookup_hit,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX = $clog2(ENTRIES);

  btb_entry_t entries_q [ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [IDX-1:0] up_idx;
  logic [31:0]    lk_tag;
  logic [31:0]    up_tag;
  btb_entry_t     lk_entry;
  btb_entry_t     up_entry;
  logic           up_hit;

  // Instruction addresses are word aligned, so the two low bits carry nothing.
  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX+1:2];
  assign up_idx = upd_pc[IDX+1:2];
  assign lk_tag = lookup_pc >> (IDX + 2);
  assign up_tag = upd_pc >> (IDX + 2);

  // Read port: tag compare against the entry selected by the fetch PC
  always_comb begin
    lk_entry      = entries_q[lk_idx];
    lookup_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
    lookup_taken  = lookup_hit && lk_entry.ctr[1];
    lookup_target = lk_entry.target;
  end

  // Training side: does the resolved branch already own its entry?
  always_comb begin
    up_entry = entries_q[up_idx];
    up_hit   = up_entry.valid && (up_entry.tag == up_tag);
  end

  // Table state: allocate on a taken miss, otherwise nudge the counter of a hit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        entries_q[up_idx].ctr <= ctr_step(up_entry.ctr, upd_taken);
        if (upd_taken) entries_q[up_idx].target <= upd_target;
      end else if (upd_taken) begin
        entries_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, slot sequence counter and next-PC priority selection.
// PC and inst_num are registered; a redirect in cycle N is visible in cycle N+1.
// stall holds the slot unless an exception or mispredict redirect overrides it.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exception_sig,
  input  logic [31:0] exception_pc,
  input  logic        mispredict,
  input  logic [31:0] mispredict_pc,
  input  logic        br_update_valid,
  input  logic [31:0] br_update_pc,
  input  logic [31:0] br_update_target,
  input  logic        br_update_taken,
  output logic [31:0] PC,
  output logic [31:0] inst_num,
  output logic        hit,
  output logic        taken
);

  logic [31:0] pred_target;
  logic [31:0] pc_next;
  logic        pc_load;

  btb_direct_mapped #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (PC),
    .lookup_hit    (hit),
    .lookup_taken  (taken),
    .lookup_target (pred_target),
    .upd_valid     (br_update_valid),
    .upd_pc        (br_update_pc),
    .upd_target    (br_update_target),
    .upd_taken     (br_update_taken)
  );

  // Next-PC priority: exception, mispredict, stall hold, predicted target, PC+4
  always_comb begin
    pc_next = PC + 32'd4;
    pc_load = 1'b1;
    if (exception_sig) begin
      pc_next = exception_pc;
    end else if (mispredict) begin
      pc_next = mispredict_pc;
    end else if (stall) begin
      pc_next = PC;
      pc_load = 1'b0;
    end else if (taken) begin
      pc_next = pred_target;
    end
  end

  // Fetch slot state: every loaded PC gets the next sequence number
  always_ff @(posedge clk) begin
    if (reset) begin
      PC       <= PC_RESET;
      inst_num <= 32'd0;
    end else if (pc_load) begin
      PC       <= pc_next;
      inst_num <= inst_num + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then random traffic.
// Outputs are compared mid-cycle against a behavioural model of fetch and BTB.
// Stall, redirects, training and resets are all driven from the bench.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exception_sig;
  logic [31:0] exception_pc;
  logic        mispredict;
  logic [31:0] mispredict_pc;
  logic        br_update_valid;
  logic [31:0] br_update_pc;
  logic [31:0] br_update_target;
  logic        br_update_taken;
  logic [31:0] pc;
  logic [31:0] inst_num;
  logic        hit;
  logic        taken;

  fetch_pc_unit #(
    .BTB_ENTRIES (16),
    .PC_RESET    (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .exception_sig    (exception_sig),
    .exception_pc     (exception_pc),
    .mispredict       (mispredict),
    .mispredict_pc    (mispredict_pc),
    .br_update_valid  (br_update_valid),
    .br_update_pc     (br_update_pc),
    .br_update_target (br_update_target),
    .br_update_taken  (br_update_taken),
    .PC               (pc),
    .inst_num         (inst_num),
    .hit              (hit),
    .taken            (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 16-entry table, indexed by word address mod 16,
  // tagged by the address divided by 64; counters kept as plain integers 0..3.
  logic [31:0] m_pc;
  logic [31:0] m_num;
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  task automatic model_reset();
    m_pc  = 32'h0;
    m_num = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
  endtask

  // One clock cycle: drive, compare against model, advance model, cross the edge
  task automatic cycle(input bit st, input bit ex, input logic [31:0] epc,
                       input bit mp, input logic [31:0] mpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utg,
                       input bit utk, input bit rst);
    int          li;
    int          ui;
    bit          m_hit;
    bit          m_taken;
    bit          u_hit;
    logic [31:0] nxt;
    reset            = rst;
    stall            = st;
    exception_sig    = ex;
    exception_pc     = epc;
    mispredict       = mp;
    mispredict_pc    = mpc;
    br_update_valid  = uv;
    br_update_pc     = upc;
    br_update_target = utg;
    br_update_taken  = utk;
    #2;
    li      = int'((m_pc / 4) % 16);
    m_hit   = m_valid[li] && (m_tag[li] == m_pc / 64);
    m_taken = m_hit && (m_ctr[li] >= 2);
    check_val("pc", pc, m_pc);
    check_val("inst_num", inst_num, m_num);
    check_val("hit", {31'b0, hit}, {31'b0, m_hit});
    check_val("taken", {31'b0, taken}, {31'b0, m_taken});
    if (rst) begin
      model_reset();
    end else begin
      if (ex)           nxt = epc;
      else if (mp)      nxt = mpc;
      else if (st)      nxt = m_pc;
      else if (m_taken) nxt = m_tgt[li];
      else              nxt = m_pc + 32'd4;
      if (ex || mp || !st) m_num = m_num + 32'd1;
      m_pc = nxt;
      if (uv) begin
        ui    = int'((upc / 4) % 16);
        u_hit = m_valid[ui] && (m_tag[ui] == upc / 64);
        if (u_hit && utk) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = utg;
        end else if (u_hit) begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end else if (utk) begin
          m_valid[ui] = 1;
          m_tag[ui]   = upc / 64;
          m_tgt[ui]   = utg;
          m_ctr[ui]   = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic redirect(input logic [31:0] a);
    cycle(0, 0, 32'h0, 1, a, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] t, input bit tk);
    cycle(0, 0, 32'h0, 0, 32'h0, 1, a, t, tk, 0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    if ($urandom_range(0, 9) == 0) r = $urandom;
    else                           r = 32'($urandom_range(0, 127)) << 2;
    return {r[31:2], 2'b00};
  endfunction

  logic [31:0] saved_num;

  initial begin
    reset = 1'b1; stall = 1'b0; exception_sig = 1'b0; exception_pc = '0;
    mispredict = 1'b0; mispredict_pc = '0; br_update_valid = 1'b0;
    br_update_pc = '0; br_update_target = '0; br_update_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_inst_num", inst_num, 32'h0);
    check_val("rst_hit", {31'b0, hit}, 32'h0);
    check_val("rst_taken", {31'b0, taken}, 32'h0);

    // Sequential fetch 0,4,8,C
    repeat (4) idle();
    check_val("seq_pc", pc, 32'h10);
    check_val("seq_num", inst_num, 32'd4);

    // Train 0x10 while fetching it: lookup sees pre-update state
    train(32'h10, 32'h40, 1);
    check_val("same_cycle_pc", pc, 32'h14);
    redirect(32'h10);
    check_val("btb_hit", {31'b0, hit}, 32'h1);
    check_val("btb_taken", {31'b0, taken}, 32'h1);
    idle();
    check_val("pred_pc", pc, 32'h40);
    check_val("pred_num", inst_num, 32'd7);

    // Two not-taken trainings: 10 -> 01 -> 00, entry stays valid
    train(32'h10, 32'h0, 0);
    train(32'h10, 32'h0, 0);
    redirect(32'h10);
    check_val("nt_hit", {31'b0, hit}, 32'h1);
    check_val("nt_taken", {31'b0, taken}, 32'h0);
    idle();
    check_val("nt_next", pc, 32'h14);

    // Three taken trainings saturate at 11; one not-taken still predicts taken
    train(32'h10, 32'h44, 1);
    train(32'h10, 32'h44, 1);
    train(32'h10, 32'h48, 1);
    train(32'h10, 32'h0, 0);
    redirect(32'h10);
    check_val("sat_taken", {31'b0, taken}, 32'h1);
    idle();
    check_val("sat_target", pc, 32'h48);

    // Stall hold at 0x20, then mispredict overrides stall
    redirect(32'h20);
    saved_num = inst_num;
    repeat (3) cycle(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    check_val("stall_pc", pc, 32'h20);
    check_val("stall_num", inst_num, saved_num);
    cycle(1, 0, 32'h0, 1, 32'h80, 0, 32'h0, 32'h0, 0, 0);
    check_val("stall_mp_pc", pc, 32'h80);
    check_val("stall_mp_num", inst_num, saved_num + 32'd1);

    // Exception beats mispredict
    cycle(0, 1, 32'h100, 1, 32'h80, 0, 32'h0, 32'h0, 0, 0);
    check_val("exc_prio", pc, 32'h100);

    // 32-bit wrap of PC+4
    redirect(32'hFFFF_FFFC);
    idle();
    check_val("pc_wrap", pc, 32'h0);

    // Mid-run reset discards pending redirect/update and clears the BTB
    cycle(0, 0, 32'h0, 1, 32'h300, 1, 32'h20, 32'h60, 1, 1);
    check_val("mid_rst_pc", pc, 32'h0);
    check_val("mid_rst_num", inst_num, 32'h0);
    redirect(32'h10);
    check_val("mid_rst_hit", {31'b0, hit}, 32'h0);
    redirect(32'h20);
    check_val("rst_drop_upd", {31'b0, hit}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit          st, ex, mp, uv, utk, rst;
      logic [31:0] upc;
      st  = ($urandom_range(0, 3) == 0);
      ex  = ($urandom_range(0, 19) == 0);
      mp  = ($urandom_range(0, 9) == 0);
      uv  = ($urandom_range(0, 2) == 0);
      utk = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      upc = ($urandom_range(0, 1) == 0) ? m_pc : rand_pc();
      cycle(st, ex, rand_pc(), mp, rand_pc(), uv, upc, rand_pc(), utk, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage front end that sits directly upstream of the IF/ID pipeline register.
- Holds the fetch PC and assigns a monotonically increasing instruction sequence number to each fetched slot.
- Looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and produces PC, inst_num, hit and taken for IF/ID to latch.
- Selects the next PC from exception redirect, mispredict redirect, stall hold, predicted target or PC+4; the BTB is trained from resolved branches.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; must be a power of two, minimum 2.
- PC_RESET, 32'h0000_0000, fetch PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold the current fetch slot (downstream back-pressure).
- exception_sig  input  1  redirect fetch to exception_pc; same signal flushes IF/ID.
- exception_pc  input  32  exception handler / recovery PC.
- mispredict  input  1  resolved branch disagreed with prediction; redirect to mispredict_pc.
- mispredict_pc  input  32  correct next PC after mispredict.
- br_update_valid  input  1  a branch resolved this cycle; train the BTB.
- br_update_pc  input  32  PC of the resolved branch.
- br_update_target  input  32  resolved target address.
- br_update_taken  input  1  resolved direction.
- PC  output  32  current fetch PC (registered).
- inst_num  output  32  sequence number of the current fetch slot (registered).
- hit  output  1  BTB tag match for PC (combinational from PC and BTB state).
- taken  output  1  predicted taken: hit && counter[1].

Behaviour:
- Reset: PC=PC_RESET, inst_num=0, all BTB valid bits cleared, all counters=2'b01. hit=0 and taken=0 in the first cycle after reset. Reset asserted mid-operation discards any pending redirect or update in that cycle.
- Index = PC[IDX+1:2] and tag = PC[31:IDX+2], where IDX = log2(BTB_ENTRIES). PC[1:0] is ignored and is always 0 by construction.
- Lookup is combinational on the registered PC: hit = valid[idx] && tag[idx]==tag(PC); taken = hit && ctr[idx][1].
- Next-PC priority, evaluated each cycle:
  1. exception_sig -> exception_pc
  2. mispredict -> mispredict_pc
  3. stall -> PC (hold)
  4. taken -> target[idx]
  5. otherwise PC+4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- Redirects override stall.
- inst_num increments by 1 on every cycle where PC loads (any case except stall hold without redirect). It wraps modulo 2^32 and is never decremented on flush.
- Single-cycle latency: a redirect asserted in cycle N makes PC equal the new target in cycle N+1.
- BTB update, on the clock edge when br_update_valid, indexed by br_update_pc:
  - Entry miss (invalid or tag mismatch) and taken: allocate with valid=1, tag, target=br_update_target, ctr=2'b10.
  - Entry miss and not taken: no change.
  - Entry hit and taken: ctr saturating increment (max 2'b11), target=br_update_target.
  - Entry hit and not taken: ctr saturating decrement (min 2'b00); valid and target retained.
- Update and lookup to the same index in the same cycle: the lookup sees pre-update contents and the update is visible next cycle.
- Updates proceed regardless of stall, exception_sig or mispredict.
- The unit does not track in-flight state; flushing younger slots is IF/ID's responsibility via exception_sig.

Decomposition:
- Shared package: PC_RESET default, counter encodings (CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11), and a BTB entry typedef (valid, tag, target, ctr).
- One sub-module, btb_direct_mapped. It has a combinational lookup port and a synchronous update port with the allocation and saturation rules above.
- fetch_pc_unit keeps the PC register, the inst_num counter and the next-PC priority mux.

Test Plan:
- Reset, then 4 cycles with no stall -> PC = 0,4,8,C; inst_num = 0,1,2,3; hit=0, taken=0 throughout.
- Update at pc=0x10, target=0x40, taken=1; then fetch reaches 0x10 -> hit=1, taken=1 at PC=0x10; next PC=0x40; inst_num increments by 1.
- Same entry trained not-taken twice (ctr 10->01->00) -> at PC=0x10, hit=1, taken=0, next PC=0x14. Three taken updates -> ctr saturates at 11.
- stall=1 for 3 cycles at PC=0x20 -> PC and inst_num held. Assert mispredict with mispredict_pc=0x80 while stall=1 -> PC=0x80 next cycle and inst_num+1.
- exception_sig and mispredict both asserted, exception_pc=0x100, mispredict_pc=0x80 -> PC=0x100. Reset mid-run after BTB training -> PC=0, inst_num=0, and the previously hitting PC now gives hit=0.
- PC=0xFFFF_FFFC with no BTB hit -> next PC=0x0. inst_num preset near wrap via 2^32-1 advances -> wraps to 0.
